// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = 16;

    typedef logic [3:0]  key_idx_t;
    typedef logic [15:0] key_map_t;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_t;

    // Row sequencing order; ROW3 wraps back to ROW0.
    function automatic row_state_t next_row(input row_state_t s);
        row_state_t n;
        case (s)
            ROW0:    n = ROW1;
            ROW1:    n = ROW2;
            ROW2:    n = ROW3;
            default: n = ROW0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module sync_2ff #(
    parameter int unsigned         WIDTH   = 4,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; reset to the idle level of the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: one-row-low row drive, synchronised column
// sampling at the end of each row dwell, per-key debounce over whole scans,
// and registered press/release event pulses.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROW_DWELL = 12000,
    parameter int unsigned DEBOUNCE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output key_map_t            key_state,
    output key_map_t            press_mask,
    output key_map_t            release_mask,
    output logic                press_valid,
    output key_idx_t            press_code,
    output logic                scan_done
);

    localparam int unsigned DW = $clog2(ROW_DWELL);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    logic [NUM_COLS-1:0] col_s;

    row_state_t          state_q;
    logic [DW-1:0]       dwell_q;
    logic [NUM_ROWS-1:0] row_n_q;
    key_map_t            snap_q;
    logic                scan_done_q;

    key_map_t            key_q,   key_d;
    key_map_t            press_q, press_d;
    key_map_t            rel_q,   rel_d;
    logic                valid_q;
    key_idx_t            code_q,  code_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic                found;

    sync_2ff #(
        .WIDTH   (NUM_COLS),
        .RST_VAL ({NUM_COLS{1'b1}})
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d_i (col_n),
        .q_o (col_s)
    );

    // Row FSM: hold each row low for ROW_DWELL cycles, capture its columns
    // on the last dwell cycle, then rotate; flag completion of ROW3.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ROW0;
            dwell_q     <= '0;
            row_n_q     <= 4'b1110;
            snap_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (dwell_q == DW'(ROW_DWELL - 1)) begin
                dwell_q <= '0;
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    snap_q[{state_q, 2'(c)}] <= ~col_s[c];
                end
                row_n_q <= {row_n_q[NUM_ROWS-2:0], row_n_q[NUM_ROWS-1]};
                state_q <= next_row(state_q);
                if (state_q == ROW3) begin
                    scan_done_q <= 1'b1;
                end
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
        end
    end

    // Per-key debounce, evaluated once per completed scan, plus lowest-index
    // priority encode of the keys that just became held.
    always_comb begin
        key_d   = key_q;
        press_d = '0;
        rel_d   = '0;
        code_d  = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (scan_done_q) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (snap_q[k] == key_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == CW'(DEBOUNCE - 1)) begin
                    key_d[k] = ~key_q[k];
                    cnt_d[k] = '0;
                    if (snap_q[k]) begin
                        press_d[k] = 1'b1;
                    end else begin
                        rel_d[k] = 1'b1;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (press_d[k] && !found) begin
                code_d = key_idx_t'(k);
                found  = 1'b1;
            end
        end
    end

    // Debounce state and event outputs; event registers self-clear because
    // press_d/rel_d are zero on every cycle except the one after a scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            key_q   <= key_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            valid_q <= |press_d;
            code_q  <= code_d;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign row_n        = row_n_q;
    assign key_state    = key_q;
    assign press_mask   = press_q;
    assign release_mask = rel_q;
    assign press_valid  = valid_q;
    assign press_code   = code_q;
    assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with ROW_DWELL=8, DEBOUNCE=2 and a
// behavioural 4x4 switch matrix driving the columns from the rows.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_state;
    logic [15:0] press_mask;
    logic [15:0] release_mask;
    logic        press_valid;
    logic [3:0]  press_code;
    logic        scan_done;

    logic [15:0] held;
    int          errors;
    int          checks;
    int          n_press;
    int          n_rel;

    keypad_scanner #(
        .ROW_DWELL (8),
        .DEBOUNCE  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col_n        (col_n),
        .row_n        (row_n),
        .key_state    (key_state),
        .press_mask   (press_mask),
        .release_mask (release_mask),
        .press_valid  (press_valid),
        .press_code   (press_code),
        .scan_done    (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a held key shorts its column low while its row is low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && held[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    // Event counters used to prove absence of pulses.
    always @(negedge clk) begin
        if (press_valid === 1'b1) n_press++;
        if (|release_mask === 1'b1) n_rel++;
    end

    task automatic wait_scan(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (scan_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s: scan_done not seen within 100 cycles, got %0b expected 1", name, seen);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        held = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (row_n !== 4'b1110) begin
            errors++; $display("FAIL reset_row_n: got %b expected 1110", row_n);
        end
        checks++;
        if ({key_state, press_mask, release_mask} !== 48'h0) begin
            errors++; $display("FAIL reset_maps: got %h/%h/%h expected 0", key_state, press_mask, release_mask);
        end
        checks++;
        if ({press_valid, press_code, scan_done} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got pv=%b pc=%h sd=%b expected 0", press_valid, press_code, scan_done);
        end
    endtask

    task automatic test_idle_scan;
        logic [3:0] exp_row;
        logic       exp_sd;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            exp_row = 4'b1111 ^ (4'b0001 << ((k / 8) % 4));
            exp_sd  = (k % 32 == 0);
            checks++;
            if (row_n !== exp_row) begin
                errors++; $display("FAIL idle_row_n cyc %0d: got %b expected %b", k, row_n, exp_row);
            end
            checks++;
            if (scan_done !== exp_sd) begin
                errors++; $display("FAIL idle_scan_done cyc %0d: got %b expected %b", k, scan_done, exp_sd);
            end
            checks++;
            if ({press_valid, release_mask, press_mask, key_state} !== 49'h0) begin
                errors++; $display("FAIL idle_quiet cyc %0d: got pv=%b rm=%h pm=%h ks=%h expected 0", k, press_valid, release_mask, press_mask, key_state);
            end
        end
    endtask

    task automatic test_press;
        held = 16'h0040;
        wait_scan("press_scan1");
        wait_scan("press_scan2");
        checks++;
        if ({press_valid, key_state} !== 17'h0) begin
            errors++; $display("FAIL press_early: got pv=%b ks=%h expected 0", press_valid, key_state);
        end
        @(negedge clk);
        checks++;
        if (press_mask !== 16'h0040) begin
            errors++; $display("FAIL press_mask: got %h expected 0040", press_mask);
        end
        checks++;
        if (press_valid !== 1'b1 || press_code !== 4'd6) begin
            errors++; $display("FAIL press_code: got pv=%b pc=%0d expected pv=1 pc=6", press_valid, press_code);
        end
        checks++;
        if (key_state !== 16'h0040 || release_mask !== 16'h0) begin
            errors++; $display("FAIL press_state: got ks=%h rm=%h expected 0040/0000", key_state, release_mask);
        end
        @(negedge clk);
        checks++;
        if (press_mask !== 16'h0 || press_valid !== 1'b0 || key_state !== 16'h0040) begin
            errors++; $display("FAIL press_one_cycle: got pm=%h pv=%b ks=%h expected 0000/0/0040", press_mask, press_valid, key_state);
        end
    endtask

    task automatic test_release;
        held = 16'h0000;
        wait_scan("release_scan1");
        wait_scan("release_scan2");
        checks++;
        if (release_mask !== 16'h0 || key_state !== 16'h0040) begin
            errors++; $display("FAIL release_early: got rm=%h ks=%h expected 0000/0040", release_mask, key_state);
        end
        @(negedge clk);
        checks++;
        if (release_mask !== 16'h0040) begin
            errors++; $display("FAIL release_mask: got %h expected 0040", release_mask);
        end
        checks++;
        if (key_state !== 16'h0 || press_valid !== 1'b0) begin
            errors++; $display("FAIL release_state: got ks=%h pv=%b expected 0000/0", key_state, press_valid);
        end
        @(negedge clk);
        checks++;
        if (release_mask !== 16'h0) begin
            errors++; $display("FAIL release_one_cycle: got %h expected 0000", release_mask);
        end
    endtask

    // Key 3 changes every scan, so no two consecutive scans agree.
    task automatic test_bounce;
        int base_p;
        int base_r;
        wait_scan("bounce_align");
        base_p = n_press;
        base_r = n_rel;
        for (int i = 0; i < 10; i++) begin
            held = (i % 2 == 0) ? 16'h0008 : 16'h0000;
            wait_scan("bounce_scan");
            checks++;
            if (key_state[3] !== 1'b0) begin
                errors++; $display("FAIL bounce_key3 scan %0d: got %b expected 0", i, key_state[3]);
            end
        end
        wait_scan("bounce_settle");
        repeat (2) @(negedge clk);
        checks++;
        if (n_press !== base_p || n_rel !== base_r) begin
            errors++; $display("FAIL bounce_events: got press=%0d rel=%0d expected 0/0", n_press - base_p, n_rel - base_r);
        end
    endtask

    task automatic test_multi;
        int base_p;
        wait_scan("multi_align");
        held = 16'h0204;
        base_p = n_press;
        wait_scan("multi_scan1");
        wait_scan("multi_scan2");
        @(negedge clk);
        checks++;
        if (press_mask !== 16'h0204 || press_valid !== 1'b1) begin
            errors++; $display("FAIL multi_mask: got pm=%h pv=%b expected 0204/1", press_mask, press_valid);
        end
        checks++;
        if (press_code !== 4'd2) begin
            errors++; $display("FAIL multi_code: got %0d expected 2", press_code);
        end
        @(negedge clk);
        checks++;
        if (n_press - base_p !== 1 || key_state !== 16'h0204) begin
            errors++; $display("FAIL multi_single: got pulses=%0d ks=%h expected 1/0204", n_press - base_p, key_state);
        end
        // Release key 9 while pressing key 5 in the same scan.
        held = 16'h0024;
        wait_scan("swap_scan1");
        wait_scan("swap_scan2");
        @(negedge clk);
        checks++;
        if (press_mask !== 16'h0020 || release_mask !== 16'h0200) begin
            errors++; $display("FAIL swap_masks: got pm=%h rm=%h expected 0020/0200", press_mask, release_mask);
        end
        checks++;
        if (press_code !== 4'd5 || key_state !== 16'h0024) begin
            errors++; $display("FAIL swap_state: got pc=%0d ks=%h expected 5/0024", press_code, key_state);
        end
        held = 16'h0000;
        wait_scan("clear_scan1");
        wait_scan("clear_scan2");
        @(negedge clk);
        checks++;
        if (release_mask !== 16'h0024 || press_valid !== 1'b0 || key_state !== 16'h0) begin
            errors++; $display("FAIL clear_all: got rm=%h pv=%b ks=%h expected 0024/0/0000", release_mask, press_valid, key_state);
        end
    endtask

    task automatic test_reset_midscan;
        wait_scan("mid_align");
        held = 16'h8000;
        repeat (19) @(negedge clk);
        checks++;
        if (row_n !== 4'b1011) begin
            errors++; $display("FAIL mid_row2: got %b expected 1011", row_n);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (row_n !== 4'b1110 || {key_state, press_mask, release_mask} !== 48'h0) begin
            errors++; $display("FAIL mid_reset: got row=%b ks=%h pm=%h rm=%h expected 1110/0", row_n, key_state, press_mask, release_mask);
        end
        checks++;
        if ({press_valid, press_code, scan_done} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_flags: got pv=%b pc=%h sd=%b expected 0", press_valid, press_code, scan_done);
        end
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            checks++;
            if (scan_done !== (k == 32 || k == 64)) begin
                errors++; $display("FAIL mid_scan_done cyc %0d: got %b expected %b", k, scan_done, (k == 32 || k == 64));
            end
            checks++;
            if (press_valid !== (k == 65)) begin
                errors++; $display("FAIL mid_press_valid cyc %0d: got %b expected %b", k, press_valid, (k == 65));
            end
            if (k == 65) begin
                checks++;
                if (press_mask !== 16'h8000 || press_code !== 4'd15 || key_state !== 16'h8000) begin
                    errors++; $display("FAIL mid_press15: got pm=%h pc=%0d ks=%h expected 8000/15/8000", press_mask, press_code, key_state);
                end
            end
        end
        held = 16'h0000;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        n_press = 0;
        n_rel   = 0;
        rst     = 1'b1;
        held    = '0;
        test_reset;
        test_idle_scan;
        test_press;
        test_release;
        test_bounce;
        test_multi;
        test_reset_midscan;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at 500000, expected finish");
        $fatal(1);
    end

endmodule
